board_vga_renderer: RTL
=======================

Name: board_vga_renderer

Overview:
- Downstream consumer of the game core's board state. Generates 640x480@60 VGA timing from the system clock and renders the 4x4 tile grid, the spawn preview above the cursor column, and the game-over and game-won overlays.
- Board inputs are sampled into a shadow frame buffer once per frame, only while the core asserts display_ready, so the screen never shows a half-updated board.

Parameters:
- CLK_DIV, 4, system clocks per pixel; a pixel tick occurs every CLK_DIV clocks.
- GRID_X0, 160, left x of grid.
- GRID_Y0, 80, top y of grid.
- TILE, 80, tile pitch in pixels.
- BORDER, 4, tile border width in pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- board_flat  in  80  16 tiles x 5-bit power; tile (r,c) is at bits [(r*4+c)*5 +: 5]; 0 means empty
- cursor_col  in  2  current drop column
- spawn_val  in  5  power of the pending tile
- game_over  in  1  loss flag
- game_won  in  1  win flag
- display_ready  in  1  core state is consistent and may be sampled
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  12  4:4:4 pixel colour
- frame_start  out  1  one-clock pulse at snapshot time

Behaviour:
- Reset values: all counters 0, hsync=1, vsync=1, rgb=0, frame_start=0, shadow registers 0. All flops are asynchronously reset.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick is asserted when the divider equals CLK_DIV-1.
  - All pixel-domain state advances only on a tick.
- Horizontal counter: 0..799, wraps. Active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter: 0..524. Increments when h wraps 799->0, and wraps 524->0. Active 0..479, sync 490..491.
- Snapshot:
  - Occurs on the tick where h=799 and v=479.
  - If display_ready=1, latch board_flat, cursor_col, spawn_val, game_over and game_won into shadow registers, and pulse frame_start for that single clk.
  - If display_ready=0, keep the old shadow and emit no pulse. The frame is repeated.
  - Rendering uses only shadow values, never live inputs.
- Pipeline, counted in pixel ticks:
  - S0: counters.
  - S1: registers the region classification (blank / grid / preview / background), tile row/col, and a border flag.
  - S2: registers the colour lookup into rgb.
  - hsync, vsync and blank are delayed two ticks so they stay aligned with rgb. Total latency is 2 ticks.
- Regions, evaluated on S0 coordinates:
  - Grid: x in [GRID_X0, GRID_X0+4*TILE-1], y in [GRID_Y0, GRID_Y0+4*TILE-1]. Tile col = (x-GRID_X0)/TILE and tile row = (y-GRID_Y0)/TILE, computed by comparison chain (no divider).
  - Border: pixel is within BORDER of any tile edge.
  - Preview: y in 8..71, x in [GRID_X0+8+TILE*cursor_col, +63].
- Colour:
  - Blank: 12'h000.
  - Border: 12'h776.
  - Tile power mapping: 0:BBA, 1:EED, 2:EDC, 3:FB7, 4:F96, 5:F75, 6:F53, 7:EC7, 8:EC6, 9:EC5, 10:EC3, 11:EC2, 12..31:3C3.
  - Preview uses the same mapping on spawn_val.
  - Background: 12'h000, or 12'h060 when shadow game_won=1.
- Game-over overlay: when shadow game_over=1, each 4-bit channel of grid and preview pixels is shifted right by 1. Border pixels are included; background is not.
- Simultaneous snapshot and rendering: the new shadow takes effect from the following tick. No active pixel is affected, since the snapshot occurs in blanking.
- Reset mid-frame: outputs are forced to their reset values immediately. Timing restarts at h=0, v=0 after release.

Test Plan:
- Timing: after reset, hsync low for exactly 96 ticks (384 clk) per 800-tick line; vsync low for 2 lines out of 525; frame_start period = 800*525*4 clk when display_ready is held 1.
- Snapshot gating: display_ready=0 across the h=799,v=479 tick -> no frame_start and rgb unchanged after board_flat changes; set display_ready=1 -> next frame shows the new board.
- Tile colour: board_flat with tile(0,0)=1 and tile(3,3)=11 -> pixel (200,120) rgb=EED; pixel (440,360) rgb=EC2; pixel (162,82), a border pixel, rgb=776; pixel (10,10) rgb=000.
- Preview: cursor_col=2, spawn_val=3 -> pixel (340,40) rgb=FB7; pixel (200,40) rgb=000.
- Overlays: game_over=1 with tile(0,0)=4 -> pixel (200,120) rgb=743 (F96>>1 per channel); game_won=1 -> pixel (10,200) rgb=060.
- Latency and reset: hsync falling edge is 2 ticks after h_count reaches 656; asserting rst mid-line gives hsync=1, vsync=1, rgb=0 within the same clk with no clock edge required.

Source files
------------

// File: rtl/board_vga_renderer.sv
`timescale 1ns/1ps
// 640x480@60 VGA renderer for the 4x4 tile board: per-frame shadow snapshot of the
// game core state, two-stage pixel pipeline (region classify, then colour lookup).
module board_vga_renderer #(
  parameter int CLK_DIV = 4,
  parameter int GRID_X0 = 160,
  parameter int GRID_Y0 = 80,
  parameter int TILE    = 80,
  parameter int BORDER  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] board_flat,
  input  logic [1:0]  cursor_col,
  input  logic [4:0]  spawn_val,
  input  logic        game_over,
  input  logic        game_won,
  input  logic        display_ready,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;
  localparam logic [9:0] V_SNAP    = 10'd479;

  localparam logic [9:0] GX0 = 10'(GRID_X0);
  localparam logic [9:0] GX1 = 10'(GRID_X0 + TILE);
  localparam logic [9:0] GX2 = 10'(GRID_X0 + 2 * TILE);
  localparam logic [9:0] GX3 = 10'(GRID_X0 + 3 * TILE);
  localparam logic [9:0] GX4 = 10'(GRID_X0 + 4 * TILE);
  localparam logic [9:0] GY0 = 10'(GRID_Y0);
  localparam logic [9:0] GY1 = 10'(GRID_Y0 + TILE);
  localparam logic [9:0] GY2 = 10'(GRID_Y0 + 2 * TILE);
  localparam logic [9:0] GY3 = 10'(GRID_Y0 + 3 * TILE);
  localparam logic [9:0] GY4 = 10'(GRID_Y0 + 4 * TILE);
  localparam logic [9:0] B_LO = 10'(BORDER);
  localparam logic [9:0] B_HI = 10'(TILE - BORDER);
  localparam logic [9:0] PV_X0   = 10'(GRID_X0 + 8);
  localparam logic [9:0] PV_TILE = 10'(TILE);
  localparam logic [9:0] PV_W    = 10'd63;
  localparam logic [9:0] PV_Y0   = 10'd8;
  localparam logic [9:0] PV_Y1   = 10'd71;

  typedef enum logic [1:0] {
    REGION_BLANK,
    REGION_GRID,
    REGION_PREVIEW,
    REGION_BACKGROUND
  } region_t;

  logic [DIV_W-1:0] div_reg;
  logic             tick;
  logic [9:0]       h_count, v_count;
  logic             snap;

  logic [79:0] shadow_board;
  logic [1:0]  shadow_cursor;
  logic [4:0]  shadow_spawn;
  logic        shadow_over, shadow_won;

  logic [1:0]  col0, row0;
  logic [9:0]  tile_x0, tile_y0, lx, ly, pv_left;
  logic        border0, in_grid, in_preview, active, hs0, vs0;
  region_t     region0;

  region_t     region_s1;
  logic [1:0]  row_s1, col_s1;
  logic        border_s1, hs_s1, vs_s1;

  logic [4:0]  tile_pow [16];
  logic [11:0] base_colour, colour_next;

  assign tick = (div_reg == DIV_LAST);
  assign snap = tick && (h_count == H_LAST) && (v_count == V_SNAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= '0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      if (tick) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

  // Snapshot lands in vertical blanking, so no visible pixel mixes old and new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_board  <= '0;
      shadow_cursor <= '0;
      shadow_spawn  <= '0;
      shadow_over   <= 1'b0;
      shadow_won    <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= snap && display_ready;
      if (snap && display_ready) begin
        shadow_board  <= board_flat;
        shadow_cursor <= cursor_col;
        shadow_spawn  <= spawn_val;
        shadow_over   <= game_over;
        shadow_won    <= game_won;
      end
    end
  end

  // Tile row/column by comparison chain against fixed boundaries.
  always_comb begin
    col0    = 2'd0;
    tile_x0 = GX0;
    if (h_count >= GX3) begin
      col0 = 2'd3; tile_x0 = GX3;
    end else if (h_count >= GX2) begin
      col0 = 2'd2; tile_x0 = GX2;
    end else if (h_count >= GX1) begin
      col0 = 2'd1; tile_x0 = GX1;
    end
    row0    = 2'd0;
    tile_y0 = GY0;
    if (v_count >= GY3) begin
      row0 = 2'd3; tile_y0 = GY3;
    end else if (v_count >= GY2) begin
      row0 = 2'd2; tile_y0 = GY2;
    end else if (v_count >= GY1) begin
      row0 = 2'd1; tile_y0 = GY1;
    end
    lx         = h_count - tile_x0;
    ly         = v_count - tile_y0;
    border0    = (lx < B_LO) || (lx >= B_HI) || (ly < B_LO) || (ly >= B_HI);
    in_grid    = (h_count >= GX0) && (h_count < GX4) && (v_count >= GY0) && (v_count < GY4);
    pv_left    = PV_X0 + PV_TILE * {8'd0, shadow_cursor};
    in_preview = (v_count >= PV_Y0) && (v_count <= PV_Y1) &&
                 (h_count >= pv_left) && (h_count <= pv_left + PV_W);
    active     = (h_count < H_ACTIVE) && (v_count < V_ACTIVE);
    hs0        = !((h_count >= H_SYNC_LO) && (h_count <= H_SYNC_HI));
    vs0        = !((v_count >= V_SYNC_LO) && (v_count <= V_SYNC_HI));
    region0    = REGION_BLANK;
    if (active) begin
      if (in_grid)         region0 = REGION_GRID;
      else if (in_preview) region0 = REGION_PREVIEW;
      else                 region0 = REGION_BACKGROUND;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_tiles
    assign tile_pow[gi] = shadow_board[gi*5 +: 5];
  end

  function automatic logic [11:0] power_colour(input logic [4:0] p);
    case (p)
      5'd0:    return 12'hBBA;
      5'd1:    return 12'hEED;
      5'd2:    return 12'hEDC;
      5'd3:    return 12'hFB7;
      5'd4:    return 12'hF96;
      5'd5:    return 12'hF75;
      5'd6:    return 12'hF53;
      5'd7:    return 12'hEC7;
      5'd8:    return 12'hEC6;
      5'd9:    return 12'hEC5;
      5'd10:   return 12'hEC3;
      5'd11:   return 12'hEC2;
      default: return 12'h3C3;
    endcase
  endfunction

  // Game-over dimming halves each 4-bit channel independently.
  function automatic logic [11:0] dim(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

  always_comb begin
    base_colour = 12'h000;
    colour_next = 12'h000;
    case (region_s1)
      REGION_GRID: begin
        base_colour = border_s1 ? 12'h776 : power_colour(tile_pow[{row_s1, col_s1}]);
        colour_next = shadow_over ? dim(base_colour) : base_colour;
      end
      REGION_PREVIEW: begin
        base_colour = power_colour(shadow_spawn);
        colour_next = shadow_over ? dim(base_colour) : base_colour;
      end
      REGION_BACKGROUND: colour_next = shadow_won ? 12'h060 : 12'h000;
      default:           colour_next = 12'h000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      region_s1 <= REGION_BLANK;
      row_s1    <= '0;
      col_s1    <= '0;
      border_s1 <= 1'b0;
      hs_s1     <= 1'b1;
      vs_s1     <= 1'b1;
      rgb       <= 12'h000;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else if (tick) begin
      region_s1 <= region0;
      row_s1    <= row0;
      col_s1    <= col0;
      border_s1 <= border0;
      hs_s1     <= hs0;
      vs_s1     <= vs0;
      rgb       <= colour_next;
      hsync     <= hs_s1;
      vsync     <= vs_s1;
    end
  end

endmodule
